// File: rtl/tp_lookup_pkg.sv
// Shared widths, requester count and FSM encoding for the lookup arbiter.
package tp_lookup_pkg;

    localparam int DEF_RAM_WIDTH     = 18;
    localparam int DEF_RAM_ADDR_BITS = 5;
    localparam int DEF_N_REQ         = 4;

    // RUN arbitrates, DRAIN waits for in-flight reads, HOLD hands the table to the host.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } lk_state_e;

    // Requester id width; never let it collapse to zero bits for a single requester.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tp_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module tp_rr_arbiter
    import tp_lookup_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ID_BITS = id_bits(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [N_REQ-1:0]   grant,
    output logic [ID_BITS-1:0] grant_id,
    output logic               grant_valid
);

    logic [ID_BITS-1:0] idx_c;

    // Scan requesters starting at the pointer, wrapping modulo N_REQ; keep the first hit.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx_c       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx_c = ID_BITS'((int'(ptr) + off) % N_REQ);
            if (!grant_valid && req[idx_c]) begin
                grant[idx_c] = 1'b1;
                grant_id     = idx_c;
                grant_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tp_lookup_arbiter.sv
// Round-robin read arbiter in front of a lookup RAM, with a host hold/rewrite handshake.
module tp_lookup_arbiter
    import tp_lookup_pkg::*;
#(
    parameter int  RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int  RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int  N_REQ         = DEF_N_REQ,
    localparam int ID_BITS       = id_bits(N_REQ)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_REQ-1:0]               REQ,
    input  logic [N_REQ*RAM_ADDR_BITS-1:0] REQ_ADDR,
    output logic [N_REQ-1:0]               ACK,
    output logic                           RSP_VALID,
    output logic [ID_BITS-1:0]             RSP_ID,
    output logic [RAM_WIDTH-1:0]           RSP_DATA,
    input  logic                           HOLD_REQ,
    output logic                           HOLD_ACK,
    input  logic                           HOST_WR,
    input  logic [RAM_ADDR_BITS-1:0]       HOST_WR_A,
    input  logic [RAM_WIDTH-1:0]           HOST_DI,
    output logic [RAM_ADDR_BITS-1:0]       MEM_READ_A,
    output logic                           MEM_RD_EN,
    output logic [RAM_ADDR_BITS-1:0]       MEM_WRITE_A,
    output logic                           MEM_WR_EN,
    output logic [RAM_WIDTH-1:0]           MEM_DI,
    input  logic [RAM_WIDTH-1:0]           MEM_DO
);

    lk_state_e                state_q, state_d;
    logic [ID_BITS-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]         ack_q, ack_d;
    logic                     rd_en_q, rd_en_d;
    logic [RAM_ADDR_BITS-1:0] read_a_q, read_a_d;
    logic [ID_BITS-1:0]       rd_id_q, rd_id_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_BITS-1:0]       rsp_id_q, rsp_id_d;
    logic                     wr_en_q, wr_en_d;
    logic [RAM_ADDR_BITS-1:0] write_a_q, write_a_d;
    logic [RAM_WIDTH-1:0]     di_q, di_d;
    logic                     hold_ack_q, hold_ack_d;

    logic [N_REQ-1:0]         grant;
    logic [ID_BITS-1:0]       grant_id;
    logic                     grant_valid;
    logic [RAM_ADDR_BITS-1:0] req_addr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign req_addr[gi] = REQ_ADDR[gi*RAM_ADDR_BITS +: RAM_ADDR_BITS];
    end

    tp_rr_arbiter #(
        .N_REQ   (N_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr (
        .req         (REQ),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Next-state: grants only in RUN, host writes only while holding, response trails read by one cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ack_d       = '0;
        rd_en_d     = 1'b0;
        read_a_d    = read_a_q;
        rd_id_d     = rd_id_q;
        rsp_valid_d = rd_en_q;
        rsp_id_d    = rd_en_q ? rd_id_q : rsp_id_q;
        wr_en_d     = 1'b0;
        write_a_d   = write_a_q;
        di_d        = di_q;
        case (state_q)
            ST_RUN: begin
                if (HOLD_REQ) begin
                    state_d = ST_DRAIN;
                end else if (grant_valid) begin
                    ack_d    = grant;
                    rd_en_d  = 1'b1;
                    read_a_d = req_addr[grant_id];
                    rd_id_d  = grant_id;
                    ptr_d    = (grant_id == ID_BITS'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            ST_DRAIN: begin
                // A withdrawn hold wins over completing the drain.
                if (!HOLD_REQ) begin
                    state_d = ST_RUN;
                end else if (!rd_en_q && !rsp_valid_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The write on the releasing edge is still honoured; reads restart one edge later.
                if (HOST_WR) begin
                    wr_en_d   = 1'b1;
                    write_a_d = HOST_WR_A;
                    di_d      = HOST_DI;
                end
                if (!HOLD_REQ) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        hold_ack_d = (state_d == ST_HOLD);
    end

    // State and registered outputs; reset throws away any read still in the pipe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            ack_q       <= '0;
            rd_en_q     <= 1'b0;
            read_a_q    <= '0;
            rd_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            wr_en_q     <= 1'b0;
            write_a_q   <= '0;
            di_q        <= '0;
            hold_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            rd_en_q     <= rd_en_d;
            read_a_q    <= read_a_d;
            rd_id_q     <= rd_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            wr_en_q     <= wr_en_d;
            write_a_q   <= write_a_d;
            di_q        <= di_d;
            hold_ack_q  <= hold_ack_d;
        end
    end

    assign ACK         = ack_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ID      = rsp_id_q;
    assign RSP_DATA    = MEM_DO;
    assign HOLD_ACK    = hold_ack_q;
    assign MEM_READ_A  = read_a_q;
    assign MEM_RD_EN   = rd_en_q;
    assign MEM_WRITE_A = write_a_q;
    assign MEM_WR_EN   = wr_en_q;
    assign MEM_DI      = di_q;

endmodule

// File: tb/tb_tp_lookup_arbiter.sv
// Bench for tp_lookup_arbiter: directed hold/reset scenarios plus randomized requesters
// checked against a round-robin reference model and a shadow copy of the table.
module tb_tp_lookup_arbiter;
    import tp_lookup_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 5;
    localparam int DW  = 18;
    localparam int IDB = 2;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    REQ;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N-1:0]    ACK;
    logic            RSP_VALID;
    logic [IDB-1:0]  RSP_ID;
    logic [DW-1:0]   RSP_DATA;
    logic            HOLD_REQ;
    logic            HOLD_ACK;
    logic            HOST_WR;
    logic [AW-1:0]   HOST_WR_A;
    logic [DW-1:0]   HOST_DI;
    logic [AW-1:0]   MEM_READ_A;
    logic            MEM_RD_EN;
    logic [AW-1:0]   MEM_WRITE_A;
    logic            MEM_WR_EN;
    logic [DW-1:0]   MEM_DI;
    logic [DW-1:0]   MEM_DO;

    tp_lookup_arbiter #(
        .RAM_WIDTH     (DW),
        .RAM_ADDR_BITS (AW),
        .N_REQ         (N)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_ADDR    (REQ_ADDR),
        .ACK         (ACK),
        .RSP_VALID   (RSP_VALID),
        .RSP_ID      (RSP_ID),
        .RSP_DATA    (RSP_DATA),
        .HOLD_REQ    (HOLD_REQ),
        .HOLD_ACK    (HOLD_ACK),
        .HOST_WR     (HOST_WR),
        .HOST_WR_A   (HOST_WR_A),
        .HOST_DI     (HOST_DI),
        .MEM_READ_A  (MEM_READ_A),
        .MEM_RD_EN   (MEM_RD_EN),
        .MEM_WRITE_A (MEM_WRITE_A),
        .MEM_WR_EN   (MEM_WR_EN),
        .MEM_DI      (MEM_DI),
        .MEM_DO      (MEM_DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Lookup RAM with one-cycle registered read; untouched by reset.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] mem_do;
    assign MEM_DO = mem_do;
    always @(posedge CLK) begin
        if (MEM_WR_EN) mem[MEM_WRITE_A] <= MEM_DI;
        if (MEM_RD_EN) mem_do <= mem[MEM_READ_A];
    end

    // Per-requester addresses packed onto REQ_ADDR.
    logic [AW-1:0] ra [N];
    always_comb begin
        REQ_ADDR = '0;
        for (int i = 0; i < N; i++) REQ_ADDR[i*AW +: AW] = ra[i];
    end

    // Reference state.
    logic [DW-1:0] tbl [2**AW];
    int            m_ptr;
    logic [N-1:0]  exp_ack;
    bit            exp_rd;
    logic [AW-1:0] exp_ra;
    int            exp_id;
    bit            exp_rv;
    int            exp_rsp_id;
    logic [AW-1:0] exp_rsp_a;
    bit            exp_wr;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    bit            exp_hack;

    int n_vec;
    int n_bad;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 32'h0B1D) ^ 32'h15A5A);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_ptr = 0; exp_ack = '0; exp_rd = 0; exp_ra = '0; exp_id = 0;
        exp_rv = 0; exp_rsp_id = 0; exp_rsp_a = '0;
        exp_wr = 0; exp_wa = '0; exp_wd = '0; exp_hack = 0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ack"}, ACK, 0);
        chk({pfx, "_rsp_valid"}, RSP_VALID, 0);
        chk({pfx, "_rsp_id"}, RSP_ID, 0);
        chk({pfx, "_hold_ack"}, HOLD_ACK, 0);
        chk({pfx, "_rd_en"}, MEM_RD_EN, 0);
        chk({pfx, "_wr_en"}, MEM_WR_EN, 0);
        chk({pfx, "_read_a"}, MEM_READ_A, 0);
        chk({pfx, "_write_a"}, MEM_WRITE_A, 0);
        chk({pfx, "_di"}, MEM_DI, 0);
    endtask

    // Predict the cycle after the coming edge from the inputs now driven.
    task automatic advance(input bit grants_on, input bit writes_on, input bit hack_next);
        int g;
        exp_rv     = exp_rd;
        exp_rsp_id = exp_id;
        exp_rsp_a  = exp_ra;
        exp_ack    = '0;
        exp_rd     = 0;
        if (grants_on) begin
            g = rr_pick(REQ, m_ptr);
            if (g >= 0) begin
                exp_ack[g] = 1'b1;
                exp_rd     = 1;
                exp_ra     = ra[g];
                exp_id     = g;
                m_ptr      = (g + 1) % N;
            end
        end
        exp_wr = writes_on && HOST_WR;
        if (exp_wr) begin
            exp_wa         = HOST_WR_A;
            exp_wd         = HOST_DI;
            tbl[HOST_WR_A] = HOST_DI;
        end
        exp_hack = hack_next;
    endtask

    task automatic tick();
        @(negedge CLK);
        chk("ack", ACK, exp_ack);
        chk("rd_en", MEM_RD_EN, exp_rd);
        if (exp_rd) chk("read_a", MEM_READ_A, exp_ra);
        chk("rsp_valid", RSP_VALID, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", RSP_ID, exp_rsp_id);
            chk("rsp_data", RSP_DATA, tbl[exp_rsp_a]);
        end
        chk("wr_en", MEM_WR_EN, exp_wr);
        if (exp_wr) begin
            chk("write_a", MEM_WRITE_A, exp_wa);
            chk("mem_di", MEM_DI, exp_wd);
        end
        chk("hold_ack", HOLD_ACK, exp_hack);
        chk("rd_wr_excl", MEM_RD_EN & MEM_WR_EN, 0);
    endtask

    task automatic step(input bit grants_on, input bit writes_on, input bit hack_next);
        advance(grants_on, writes_on, hack_next);
        tick();
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        for (int a = 0; a < 2**AW; a++) begin
            mem[a] = init_val(a);
            tbl[a] = init_val(a);
        end
        mem_do = '0;
        RST = 1'b1; REQ = '0; HOLD_REQ = 0; HOST_WR = 0; HOST_WR_A = '0; HOST_DI = '0;
        for (int i = 0; i < N; i++) ra[i] = '0;
        reset_model();

        // Reset state
        @(negedge CLK); chk_zero("rst");
        @(negedge CLK); chk_zero("rst");
        RST = 1'b0;

        // All four requesting for eight edges: 0,1,2,3,0,1,2,3
        for (int i = 0; i < N; i++) ra[i] = AW'(i * 3 + 1);
        REQ = '1;
        for (int c = 0; c < 8; c++) step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Single read of address 5 by requester 0
        ra[0] = 5; REQ = 4'b0001;
        step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Hold during continuous reads, rewrite address 7, release and read back
        for (int i = 0; i < N; i++) ra[i] = AW'(i + 10);
        REQ = '1;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        HOLD_REQ = 1;
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
        HOST_WR = 1; HOST_WR_A = 7; HOST_DI = 18'h0002A;
        step(0, 1, 1);
        HOST_WR = 0;
        step(0, 1, 1);
        HOST_WR = 1; HOST_WR_A = 9; HOST_DI = 18'h00155; HOLD_REQ = 0;
        step(0, 1, 0);
        HOST_WR = 0; ra[0] = 7; ra[1] = 9; ra[2] = 7; ra[3] = 9;
        for (int c = 0; c < 4; c++) step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Host write while running must be ignored; address 3 keeps its contents
        HOST_WR = 1; HOST_WR_A = 3; HOST_DI = 18'h3FFFF; ra[2] = 3; REQ = 4'b0100;
        step(1, 0, 0);
        HOST_WR = 0; REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Hold withdrawn during drain: back to RUN, no HOLD_ACK, write ignored
        HOLD_REQ = 1; HOST_WR = 1; HOST_WR_A = 4; HOST_DI = 18'h11111;
        step(0, 0, 0);
        HOLD_REQ = 0; ra[1] = 4; REQ = 4'b0010;
        step(0, 0, 0);
        HOST_WR = 0;
        step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Randomized requesters
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (ACK[i]) begin
                    if ($urandom_range(1, 0) == 0) REQ[i] = 1'b0;
                    else ra[i] = AW'($urandom);
                end else if (!REQ[i] && $urandom_range(2, 0) == 0) begin
                    REQ[i] = 1'b1;
                    ra[i]  = AW'($urandom);
                end
            end
            HOST_WR   = ($urandom_range(1, 0) == 1);
            HOST_WR_A = AW'($urandom);
            HOST_DI   = DW'($urandom);
            step(1, 0, 0);
        end
        REQ = '0; HOST_WR = 0;
        step(1, 0, 0); step(1, 0, 0);

        // Reset while a read is in flight: response is discarded
        ra[2] = 6; REQ = 4'b0100;
        step(1, 0, 0);
        REQ = '0; RST = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge CLK); chk_zero("rst_mid");
        for (int i = 0; i < N; i++) ra[i] = AW'(20 + i);
        REQ = 4'b1010; RST = 1'b0;
        reset_model();
        step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        // Reset while holding drops HOLD_ACK at once
        HOLD_REQ = 1;
        step(0, 0, 0); step(0, 0, 1);
        RST = 1'b1;
        #1 chk_zero("rst_hold");
        @(negedge CLK);
        HOLD_REQ = 0; RST = 1'b0;
        reset_model();
        ra[3] = 7; REQ = 4'b1000;
        step(1, 0, 0);
        REQ = '0;
        step(1, 0, 0); step(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
